prg_host_link: RTL and testbench

- Host-side controller for the tt_um_prg byte-serial protocol.
- Accepts one 40-bit seed word (in1,in2,in3,R0,R1) on a valid/ready request port.
- Resets the target, streams the 5 bytes out with a load strobe, waits for the target's ready flag, then captures the 3 result bytes (out1,out2,out3).
- Returns the 3 bytes as a 24-bit response with valid/ready.

---
 rtl/prg_host_link.sv | 121 ++++++++++++
 tb/tb_prg_host_link.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prg_host_link.sv
// prg_host_link: host-side sequencer for the tt_um_prg byte-serial target (reset, load 5 bytes, wait ready, capture 3 bytes).
// Optional WAIT watchdog enabled by defining PRG_HOST_TIMEOUT_EN.
module prg_host_link #(
  parameter int RST_CYC     = 2,
  parameter int FIRST_DLY   = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [39:0] req_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [23:0] rsp_data,
  output logic        rsp_err,
  output logic        tgt_rst_n,
  output logic        tgt_load,
  output logic [7:0]  tgt_data,
  input  logic        tgt_rdy,
  input  logic [7:0]  tgt_q,
  output logic        busy
);
  localparam int M1   = RST_CYC > 5 ? RST_CYC : 5;
  localparam int M2   = M1 > FIRST_DLY + 2 ? M1 : FIRST_DLY + 2;
  localparam int MAXV = M2 > TIMEOUT_CYC ? M2 : TIMEOUT_CYC;
  localparam int CW   = $clog2(MAXV + 1) + 1;

  typedef enum logic [2:0] {IDLE, TRST, LOAD, WAIT, CAP, RESP} state_t;

  state_t        r_state, w_nxt;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [39:0]   r_sh;
  logic [23:0]   r_rsp_data;
  logic          r_req_ready, r_rsp_valid, r_rsp_err, r_tgt_rst_n, r_tgt_load, r_busy;
  logic [7:0]    r_tgt_data;
  logic          w_to, w_cap;

  always_comb begin
    w_nxt = r_state;
    w_cnt = r_cnt + 1'b1;
    w_to  = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt = '0;
        if (req_valid && r_req_ready) w_nxt = TRST;
      end
      TRST: if (r_cnt == CW'(RST_CYC - 1)) begin
        w_nxt = LOAD;
        w_cnt = '0;
      end
      LOAD: if (r_cnt == CW'(4)) begin
        w_nxt = WAIT;
        w_cnt = '0;
      end
      WAIT: begin
        if (tgt_rdy) begin
          w_nxt = CAP;
          w_cnt = '0;
        end
`ifdef PRG_HOST_TIMEOUT_EN
        else if (r_cnt == CW'(TIMEOUT_CYC - 1)) begin
          w_nxt = RESP;
          w_to  = 1'b1;
        end
`else
        else w_cnt = r_cnt;
`endif
      end
      CAP: if (r_cnt == CW'(FIRST_DLY + 1)) w_nxt = RESP;
      RESP: begin
        w_cnt = r_cnt;
        if (rsp_ready) w_nxt = IDLE;
      end
      default: w_nxt = IDLE;
    endcase
  end

  // result bytes arrive on consecutive edges starting FIRST_DLY edges after ready
  assign w_cap = (r_state == CAP) && (r_cnt >= CW'(FIRST_DLY - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_sh        <= '0;
      r_rsp_data  <= '0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_tgt_rst_n <= 1'b0;
      r_tgt_load  <= 1'b0;
      r_tgt_data  <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_nxt;
      r_cnt       <= w_cnt;
      r_req_ready <= w_nxt == IDLE;
      r_busy      <= w_nxt != IDLE;
      r_rsp_valid <= w_nxt == RESP;
      r_tgt_rst_n <= !(w_nxt inside {IDLE, TRST});
      r_tgt_load  <= w_nxt == LOAD;
      r_tgt_data  <= w_nxt == LOAD ? r_sh[39:32] : 8'h00;
      if (r_state == IDLE) r_sh <= req_data;
      else if (w_nxt == LOAD) r_sh <= {r_sh[31:0], 8'h00};
      if (w_cap) r_rsp_data <= {r_rsp_data[15:0], tgt_q};
      else if (w_to) r_rsp_data <= '0;
      if (r_state == IDLE) r_rsp_err <= 1'b0;
      else if (w_to) r_rsp_err <= 1'b1;
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign tgt_rst_n = r_tgt_rst_n;
  assign tgt_load  = r_tgt_load;
  assign tgt_data  = r_tgt_data;
  assign busy      = r_busy;
endmodule

// File: tb/tb_prg_host_link.sv
// tb_prg_host_link: table-driven and randomized checks of prg_host_link against a behavioural target model.
module tb_prg_host_link;
  localparam int RC = 2, FD = 2, TO = 64;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
  logic [39:0] req_data;
  logic [23:0] rsp_data;
  logic        tgt_rst_n, tgt_load, tgt_rdy, busy;
  logic [7:0]  tgt_data, tgt_q;
  int          n_tests = 0, n_fail = 0, tgt_lat = 0;

  prg_host_link #(.RST_CYC(RC), .FIRST_DLY(FD), .TIMEOUT_CYC(TO)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .tgt_rst_n(tgt_rst_n), .tgt_load(tgt_load), .tgt_data(tgt_data), .tgt_rdy(tgt_rdy),
    .tgt_q(tgt_q), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [39:0] seed;
    int          lat;
    int          hold;
    logic [23:0] exp;
  } vec_t;

  // target function: out1 = in1^in2, out2 = in3+R0, out3 = R1^5A
  function automatic logic [23:0] ref_f(input logic [39:0] s);
    return {s[39:32] ^ s[31:24], s[23:16] + s[15:8], s[7:0] ^ 8'h5A};
  endfunction

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // behavioural target: collects 5 load bytes, raises rdy after tgt_lat cycles, presents results FD edges later
  initial begin
    logic [7:0] b[5];
    int nb, w, ph;
    tgt_rdy = 1'b0; tgt_q = 8'h00; nb = 0; w = 0; ph = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!tgt_rst_n) begin
        nb = 0; w = 0; ph = 0; tgt_rdy = 1'b0; tgt_q = 8'($urandom);
      end else if (tgt_load) begin
        if (nb < 5) b[nb] = tgt_data;
        nb++;
      end else if (nb == 5) begin
        if (ph == 0 && tgt_lat >= 0 && w == tgt_lat) begin
          tgt_rdy = 1'b1; ph = 1;
        end else if (ph == 0) w++;
        else ph++;
        tgt_q = ph == FD + 1 ? b[0] ^ b[1] : ph == FD + 2 ? b[2] + b[3] :
                ph == FD + 3 ? b[4] ^ 8'h5A : 8'($urandom);
      end
    end
  end

  task automatic send(input logic [39:0] s);
    int k = 0;
    req_valid = 1'b1; req_data = s;
    while (!req_ready && k < 50) begin tick; k++; end
    chk("req_ready_wait", req_ready, 1);
    tick;
    req_valid = 1'b0; req_data = {8'($urandom), $urandom};
    chk("accept_busy", busy, 1);
    chk("accept_req_ready", req_ready, 0);
  endtask

  task automatic stream(input logic [39:0] s);
    int k = 0;
    while (!tgt_load && k < 20) begin
      chk("trst_rst_n", tgt_rst_n, 0);
      tick; k++;
    end
    chk("rst_hold_cycles", k, RC);
    for (int i = 0; i < 5; i++) begin
      chk("load_on", tgt_load, 1);
      chk("load_rst_n_hi", tgt_rst_n, 1);
      chk("load_byte", tgt_data, s[39-8*i -: 8]);
      tick;
    end
    chk("load_off", tgt_load, 0);
    chk("load_data_zero", tgt_data, 0);
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 2000) begin
      chk("wait_busy", busy, 1);
      tick; n++;
    end
  endtask

  task automatic finish_rsp(input int hold, input logic [23:0] e, input logic err);
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", rsp_valid, 1);
      chk("hold_data", rsp_data, e);
      chk("hold_err", rsp_err, err);
      chk("hold_req_ready", req_ready, 0);
      tick;
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    chk("rsp_drop", rsp_valid, 0);
    chk("idle_tgt_rst_n", tgt_rst_n, 0);
    chk("idle_busy", busy, 0);
    chk("idle_req_ready", req_ready, 1);
  endtask

  task automatic run_txn(input vec_t v);
    int n;
    tgt_lat = v.lat;
    send(v.seed);
    stream(v.seed);
    wait_rsp(n);
    chk("rsp_latency", n, v.lat + FD + 3);
    chk("rsp_data", rsp_data, v.exp);
    chk("rsp_err", rsp_err, 0);
    finish_rsp(v.hold, v.exp, 1'b0);
  endtask

  initial begin
    vec_t tv[8];
    logic [39:0] sa, sb;
    int n, k, bad;
    req_valid = 1'b0; rsp_ready = 1'b0; req_data = '0;
    tv[0] = '{40'h0102030405, 0, 0, 24'h03075F};
    tv[1] = '{40'hFFEEDDCCBB, 3, 2, 24'h11A9E1};
    for (int i = 2; i < 8; i++) begin
      sa = {8'($urandom), $urandom};
      tv[i] = '{sa, int'($urandom_range(0, 6)), int'($urandom_range(0, 3)), ref_f(sa)};
    end

    repeat (2) tick;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_tgt_rst_n", tgt_rst_n, 0);
    chk("rst_tgt_load", tgt_load, 0);
    chk("rst_tgt_data", tgt_data, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    chk("first_cycle_req_ready", req_ready, 0);
    tick;
    chk("second_cycle_req_ready", req_ready, 1);

    for (int i = 0; i < 8; i++) run_txn(tv[i]);

    // backpressure with a second seed waiting
    sa = {8'($urandom), $urandom};
    sb = {8'($urandom), $urandom};
    tgt_lat = 1;
    send(sa);
    stream(sa);
    wait_rsp(n);
    chk("bp_data_a", rsp_data, ref_f(sa));
    req_valid = 1'b1; req_data = sb;
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", rsp_valid, 1);
      chk("bp_data_stable", rsp_data, ref_f(sa));
      chk("bp_req_ready", req_ready, 0);
      tick;
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    chk("bp_rsp_drop", rsp_valid, 0);
    chk("bp_req_ready_up", req_ready, 1);
    tick;
    chk("bp_accept_b", req_ready, 0);
    chk("bp_busy_b", busy, 1);
    req_valid = 1'b0; req_data = '0;
    stream(sb);
    wait_rsp(n);
    chk("bp_data_b", rsp_data, ref_f(sb));
    finish_rsp(0, ref_f(sb), 1'b0);

    // asynchronous reset during the third load byte
    sa = 40'h1122334455;
    tgt_lat = 0;
    send(sa);
    k = 0;
    while (!tgt_load && k < 20) begin tick; k++; end
    tick; tick;
    chk("mid_load_byte3", tgt_data, 8'h33);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_load", tgt_load, 0);
    chk("arst_tgt_rst_n", tgt_rst_n, 0);
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_busy", busy, 0);
    tick;
    rst_n = 1'b1;
    tick;
    run_txn('{40'hFFEEDDCCBB, 2, 1, 24'h11A9E1});

    // target never raises ready
    sa = {8'($urandom), $urandom};
    tgt_lat = -1;
    send(sa);
    stream(sa);
`ifdef PRG_HOST_TIMEOUT_EN
    wait_rsp(n);
    chk("timeout_edges", n, TO);
    chk("timeout_err", rsp_err, 1);
    chk("timeout_data", rsp_data, 0);
    finish_rsp(2, 24'h0, 1'b1);
`else
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      if (!busy || rsp_valid) bad++;
      tick;
    end
    chk("no_timeout_busy", bad, 0);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
`endif
    sa = {8'($urandom), $urandom};
    run_txn('{sa, 4, 0, ref_f(sa)});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
